stream_width_downsizer: RTL
===========================

# stream_width_downsizer

Parametrised wide-to-narrow stream converter. It accepts one IN_W-bit word per handshake and emits it as RATIO consecutive OUT_W-bit slices, in a configurable slice order. It has full valid/ready backpressure on both sides and sustains one slice per clock with no bubble between words. It sits between the test-pattern generator and the narrow FIFO/SDRAM write path and replaces the fixed 32→16 strobe splitter, which had no backpressure.

## Interface
- OUT_W, 16: output slice width in bits, ≥1
- RATIO, 2: slices per input word, ≥2; IN_W = OUT_W*RATIO
- MSB_FIRST, 1: 1 emits the most-significant slice first, 0 emits the least-significant slice first
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  IN_W  input word
- in_valid  in  1  input word present
- in_ready  out  1  block accepts in_data this cycle; combinational
- out_data  out  OUT_W  current slice; registered
- out_valid  out  1  out_data valid; registered
- out_ready  in  1  sink accepts the slice this cycle
- out_last  out  1  current slice is the final slice of its word; registered
- busy  out  1  a word is held (equals out_valid)

## Operation
- Storage:
  - hold register `word` (IN_W bits)
  - slice counter `cnt` (width clog2(RATIO), range 0..RATIO-1)
  - flag `full`
- States:
  - EMPTY (full=0)
  - EMIT (full=1)
- Input acceptance: in_accept = in_valid & in_ready, where in_ready = !rst & (!full | (out_ready & out_last)).
- Output acceptance: out_accept = out_valid & out_ready.
- EMPTY:
  - in_accept → load word, cnt=0, go to EMIT.
  - Otherwise stay in EMPTY.
- EMIT, out_accept with cnt<RATIO-1 → cnt+1; shift word by OUT_W toward the emit end.
  - MSB_FIRST=1: shift left.
  - MSB_FIRST=0: shift right.
- EMIT, out_accept with cnt=RATIO-1:
  - If in_accept in the same cycle → reload word, cnt=0, stay in EMIT (back-to-back).
  - Otherwise → go to EMPTY.
- EMIT, no out_accept → hold everything; out_data, out_last and cnt stay stable.
- Slice order:
  - MSB_FIRST=1: slice k = in_data[IN_W-1-k*OUT_W -: OUT_W].
  - MSB_FIRST=0: slice k = in_data[k*OUT_W +: OUT_W].
- out_data = emit-end OUT_W bits of word. out_last = full & (cnt==RATIO-1).
- No data is ever dropped or duplicated. in_valid while in_ready=0 is held off by the source; the block does not capture it.

## Timing
- Reset values (cycle after rst sampled high): out_valid=0, out_last=0, out_data=0, busy=0, cnt=0, full=0, word=0. in_ready=0 while rst is high.
- Reset mid-word: the held word is discarded; the first post-reset slice comes from a newly accepted word.
- Latency: word accepted at edge t → slice 0 on out_data/out_valid after edge t, i.e. visible in cycle t+1.
- Throughput: with in_valid and out_ready held high, out_valid stays 1 continuously. One word is consumed every RATIO cycles.
- in_ready rises in the cycle the last slice is presented with out_ready=1. This enables a zero-bubble reload.
- out_ready deasserting on the last slice stalls both sides; in_ready=0 until the slice is accepted.
- cnt never exceeds RATIO-1; it wraps to 0 only on a reload.

## Test plan
- Reset, then MSB_FIRST=1, RATIO=2, OUT_W=16, single word 0xAABB_CCDD, out_ready=1 → 0xAABB (last=0), then 0xCCDD (last=1), then out_valid=0; in_ready=1 from the cycle after rst falls.
- MSB_FIRST=0, RATIO=4, OUT_W=8, word 0x1122_3344 → 0x44, 0x33, 0x22, 0x11; out_last only on 0x11.
- Streaming at RATIO=2 with words 0x0001_0002, 0x0003_0004, 0x0005_0006, out_ready=1 → 0x0001..0x0006 on six consecutive cycles with no out_valid gap; in_ready high exactly on the cycles with out_last=1.
- Random out_ready (≈50 %) with 100 random words → output equals the scoreboard slice sequence. out_data and out_last are stable while out_valid=1 and out_ready=0. No in_accept occurs while a non-last slice is pending.
- rst asserted after slice 0 of 0xDEAD_BEEF → after reset out_valid=0 and 0xBEEF never appears. Next word 0x1234_5678 yields 0x1234, 0x5678.
- Stall on the last slice (out_ready=0 for 5 cycles, in_valid=1) → in_ready=0 for all 5 cycles. Input is accepted in the same cycle out_ready returns, and slice 0 of the new word follows immediately.

Source files
------------

// File: rtl/stream_width_downsizer.sv
// Wide-to-narrow stream converter: one IN_W word in, RATIO OUT_W slices out,
// with valid/ready on both sides and zero-bubble reload on the last slice.
module stream_width_downsizer #(
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned RATIO     = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OUT_W*RATIO-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned IN_W    = OUT_W * RATIO;
    localparam int unsigned CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    typedef enum logic {
        EMPTY,
        EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    logic full;
    logic at_last;
    logic in_accept;
    logic out_accept;

    assign full       = (state_q == EMIT);
    assign at_last    = (cnt_q == CNT_MAX);
    assign in_ready   = !rst && (!full || (out_ready && last_q));
    assign in_accept  = in_valid && in_ready;
    assign out_accept = full && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            word_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (in_accept) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_accept && at_last && !in_accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // in_accept while EMIT only happens as the last slice leaves, so a load always wins
        if (in_accept) begin
            word_d = in_data;
            cnt_d  = '0;
        end else if (out_accept && !at_last) begin
            word_d = MSB_FIRST ? (word_q << OUT_W) : (word_q >> OUT_W);
            cnt_d  = cnt_q + 1'b1;
        end

        last_d = (state_d == EMIT) && (cnt_d == CNT_MAX);
    end

    always_comb begin
        out_valid = full;
        busy      = full;
        out_last  = last_q;
        if (MSB_FIRST) begin
            out_data = word_q[IN_W-1 -: OUT_W];
        end else begin
            out_data = word_q[OUT_W-1:0];
        end
    end

endmodule
